// File: rtl/nout_display_driver_pkg.sv
// ============================================================================
// Module  : disp_pkg
// Purpose : Shared types, glyph constants and helpers for nout_display_driver.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package disp_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int BCD_W      = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } disp_state_e;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = SEG_0;  4'h1: g = SEG_1;  4'h2: g = SEG_2;  4'h3: g = SEG_3;
      4'h4: g = SEG_4;  4'h5: g = SEG_5;  4'h6: g = SEG_6;  4'h7: g = SEG_7;
      4'h8: g = SEG_8;  4'h9: g = SEG_9;  4'hA: g = SEG_A;  4'hB: g = SEG_B;
      4'hC: g = SEG_C;  4'hD: g = SEG_D;  4'hE: g = SEG_E;  default: g = SEG_F;
    endcase
    return g;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nout_display_driver_if.sv
// ============================================================================
// Module  : nout_display_driver_if
// Purpose : Core-output / display-pin bundle for nout_display_driver.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface nout_display_driver_if;
  logic [7:0] din;
  logic       halt;
  logic [3:0] state_no;
  logic [6:0] seg;
  logic [3:0] an;
  logic       halt_led;
  logic       busy;

  modport master (output din, halt, state_no, input seg, an, halt_led, busy);
  modport slave  (input din, halt, state_no, output seg, an, halt_led, busy);
endinterface

`default_nettype wire

// File: rtl/nout_display_driver_bin2bcd_seq.sv
// ============================================================================
// Module  : bin2bcd_seq
// Purpose : Sequential double-dabble, one shift per clock, 8 shifts per value.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2bcd_seq
  import disp_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start_i,
  input  logic [7:0]       din_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [BCD_W-1:0] bcd_o
);

  logic [19:0] shift_q;
  logic [19:0] dab_d;
  logic [2:0]  cnt_q;
  logic        busy_q;

  always_comb begin
    dab_d = shift_q;
    for (int i = 0; i < 3; i++) begin
      if (dab_d[8+4*i +: 4] >= 4'd5)
        dab_d[8+4*i +: 4] = dab_d[8+4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (start_i) begin
      shift_q <= {12'b0, din_i};
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      shift_q <= {dab_d[18:0], 1'b0};
      cnt_q   <= cnt_q + 3'd1;
      if (cnt_q == 3'd7)
        busy_q <= 1'b0;
    end
  end

  // Asserted during the cycle whose closing edge performs the eighth shift
  assign done_o = busy_q && (cnt_q == 3'd7);
  assign busy_o = busy_q;
  assign bcd_o  = shift_q[19:8];

endmodule

`default_nettype wire

// File: rtl/nout_display_driver.sv
// ============================================================================
// Module  : nout_display_driver
// Purpose : Nout to 3-digit decimal plus state hex on a 4-digit muxed display.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module nout_display_driver
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV    = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  nout_display_driver_if.slave  bus
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  disp_state_e      state_q, state_d;
  logic [7:0]       last_val_q;
  logic [3:0]       hund_q, tens_q, ones_q, state_lat_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q;
  logic             halt_led_q;
  logic             conv_start, conv_commit, conv_busy, conv_done, wrap;
  logic [BCD_W-1:0] conv_bcd;

  bin2bcd_seq u_bin2bcd (
    .clock   (clock),
    .reset   (reset),
    .start_i (conv_start),
    .din_i   (bus.din),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.din != last_val_q) state_d = CONV;
      CONV:    if (conv_done) state_d = COMMIT;
               else if (!conv_busy) state_d = IDLE;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    conv_start  = (state_q == IDLE) && (bus.din != last_val_q);
    conv_commit = (state_q == COMMIT);
    bus.busy    = (state_q != IDLE);
  end

  // Scan position and glyph for the digit that becomes lit on the next edge
  always_comb begin
    wrap  = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    idx_d = wrap ? idx_q + 2'd1 : idx_q;
    seg_d = SEG_BLANK;
    case (idx_d)
      2'd0: seg_d = hex_glyph(ones_q);
      2'd1: seg_d = (hund_q == 4'd0 && tens_q == 4'd0) ? SEG_BLANK : hex_glyph(tens_q);
      2'd2: seg_d = (hund_q == 4'd0) ? SEG_BLANK : hex_glyph(hund_q);
      default: seg_d = hex_glyph((idx_q != 2'd3) ? bus.state_no : state_lat_q);
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      last_val_q  <= '0;
      hund_q      <= '0;
      tens_q      <= '0;
      ones_q      <= '0;
      state_lat_q <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      seg_q       <= SEG_BLANK;
      an_q        <= '0;
      halt_led_q  <= 1'b0;
    end else begin
      if (conv_start) last_val_q <= bus.din;
      if (conv_commit) begin
        hund_q <= conv_bcd[11:8];
        tens_q <= conv_bcd[7:4];
        ones_q <= conv_bcd[3:0];
      end
      if (idx_d == 2'd3 && idx_q != 2'd3) state_lat_q <= bus.state_no;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      an_q       <= 4'b0001 << idx_d;
      halt_led_q <= bus.halt;
    end
  end

  assign bus.seg      = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
  assign bus.an       = an_q;
  assign bus.halt_led = halt_led_q;

endmodule

`default_nettype wire

// File: tb/tb_nout_display_driver.sv
// ============================================================================
// Module  : tb_nout_display_driver
// Purpose : Directed self-checking bench for nout_display_driver (REFRESH_DIV=4).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nout_display_driver;

  // Active-low (inverted) glyph values the display pins should show
  localparam logic [6:0] P_BLANK = 7'h7F;
  localparam logic [6:0] P_0     = 7'h40;
  localparam logic [6:0] P_1     = 7'h79;
  localparam logic [6:0] P_2     = 7'h24;
  localparam logic [6:0] P_3     = 7'h30;
  localparam logic [6:0] P_5     = 7'h12;
  localparam logic [6:0] P_7     = 7'h78;
  localparam logic [6:0] P_9     = 7'h10;
  localparam logic [6:0] P_A     = 7'h08;

  logic clock = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  nout_display_driver_if bus ();

  nout_display_driver #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (bus.busy && k < 30) begin
      k++;
      @(negedge clock);
    end
    if (bus.busy) check_eq({tag, "_timeout"}, 32'(bus.busy), 32'd0);
  endtask

  // Advance one cycle so seg reflects freshly committed digits, then find the digit
  task automatic wait_digit(input int idx, input logic [6:0] exp, input string tag);
    logic [3:0] want;
    int k = 0;
    want = 4'b0001 << idx;
    @(negedge clock);
    while (bus.an != want && k < 20) begin
      k++;
      @(negedge clock);
    end
    check_eq(tag, {21'd0, bus.an, bus.seg}, {21'd0, want, exp});
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy && n < 30) begin
      n++;
      @(negedge clock);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         n;
    logic [6:0] exp_seg;
    logic [3:0] seq [5];
    logic [3:0] prev;
    int         bad;
    int         k;

    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    reset = 1'b0; bus.din = 8'd0; bus.halt = 1'b0; bus.state_no = 4'd0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check_eq("rst_seg",  32'(bus.seg), 32'(P_BLANK));
    check_eq("rst_an",   32'(bus.an), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_halt", 32'(bus.halt_led), 32'd0);

    reset = 1'b1;
    @(negedge clock);
    check_eq("first_scan", {21'd0, bus.an, bus.seg}, {21'd0, 4'b0001, P_0});

    // 9: busy for exactly 9 cycles, only the ones digit lit
    bus.din = 8'd9;
    @(negedge clock);
    count_busy(n);
    check_eq("busy_len_9", 32'(n), 32'd9);
    wait_digit(0, P_9, "d9_ones");
    wait_digit(1, P_BLANK, "d9_tens");
    wait_digit(2, P_BLANK, "d9_hund");

    // 255: largest input
    bus.din = 8'd255;
    @(negedge clock);
    wait_idle("w255");
    wait_digit(2, P_2, "d255_hund");
    wait_digit(1, P_5, "d255_tens");
    wait_digit(0, P_5, "d255_ones");

    // 100 then 37 arriving at E4: 100 commits, 37 is recaptured next edge
    bus.din = 8'd100;
    @(negedge clock);
    repeat (3) @(negedge clock);
    bus.din = 8'd37;
    wait_idle("w100");
    @(negedge clock);
    check_eq("recapture", 32'(bus.busy), 32'd1);
    case (bus.an)
      4'b0100: exp_seg = P_1;
      default: exp_seg = P_0;
    endcase
    check_eq("d100_shown", 32'(bus.seg), 32'(exp_seg));
    count_busy(n);
    check_eq("busy_len_37", 32'(n), 32'd9);
    wait_digit(0, P_7, "d37_ones");
    wait_digit(1, P_3, "d37_tens");
    wait_digit(2, P_BLANK, "d37_hund");

    // Scan order, dwell, state digit and halt LED
    bus.state_no = 4'hA;
    bus.halt = 1'b1;
    check_eq("halt_pre", 32'(bus.halt_led), 32'd0);
    @(negedge clock);
    check_eq("halt_led", 32'(bus.halt_led), 32'd1);
    prev = bus.an;
    k = 0;
    do begin
      prev = bus.an;
      @(negedge clock);
      k++;
    end while (!(bus.an == 4'b0001 && prev == 4'b1000) && k < 40);
    check_eq("scan_sync", 32'(k < 40), 32'd1);
    bad = 0;
    for (int s = 0; s < 5; s++) begin
      for (int c = 0; c < 4; c++) begin
        if (bus.an != seq[s]) bad++;
        if (s == 3 && c == 1) bus.state_no = 4'h5;
        if (s == 3 && c == 3) check_eq("state_digit", 32'(bus.seg), 32'(P_A));
        @(negedge clock);
      end
    end
    check_eq("scan_seq", 32'(bad), 32'd0);

    // Reset at E3 of a conversion of 200
    bus.din = 8'd200;
    @(negedge clock);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
    check_eq("mid_rst_pins", {21'd0, bus.an, bus.seg}, {21'd0, 4'b0000, P_BLANK});
    check_eq("mid_rst_halt", 32'(bus.halt_led), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check_eq("rearm_busy", 32'(bus.busy), 32'd1);
    check_eq("rearm_zero", {21'd0, bus.an, bus.seg}, {21'd0, 4'b0001, P_0});
    wait_idle("w200");
    wait_digit(2, P_2, "d200_hund");
    wait_digit(1, P_0, "d200_tens");
    wait_digit(0, P_0, "d200_ones");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/nout_display_driver.md
Name: nout_display_driver

Overview:
- Downstream consumer of the processor core's output stage: takes the 8-bit output value (Nout), halt flag and 4-bit state number, and drives a 4-digit multiplexed seven-segment display plus a halt LED.
- Converts the binary output to 3-digit decimal with a sequential double-dabble engine. Shows the state number as one hex digit.
- Needs no strobe from the core: a change on the input value starts a conversion.

Parameters:
- REFRESH_DIV, 16, clock cycles each digit is lit before the scan advances (>=2).
- SEG_ACTIVE_LOW, 1, 1 = segment lines active-low (common anode); 0 = active-high.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- din  in  8  output value from the core (Nout).
- halt  in  1  core halt flag.
- state_no  in  4  core state number.
- seg  out  7  segment lines {g,f,e,d,c,b,a}; polarity set by SEG_ACTIVE_LOW.
- an  out  4  digit enables, one-hot, active-high. Bit 0 = ones, 1 = tens, 2 = hundreds, 3 = state.
- halt_led  out  1  registered copy of halt.
- busy  out  1  high while a conversion is in progress.

Behaviour:
- Reset (reset==0 at an edge), all registers cleared:
  - FSM = IDLE; last_val = 0; BCD display regs (hund, tens, ones) = 0.
  - refresh counter = 0; digit index = 0.
  - seg = blank (all segments off for the chosen polarity); an = 4'b0000; busy = 0; halt_led = 0.
  - Reset applied mid-conversion aborts the conversion with no partial commit.
- First edge after reset release: an = 4'b0001, seg = glyph '0'.
- FSM states IDLE, CONV, COMMIT:
  - IDLE: if din != last_val at edge E0, then shift reg <= {12'b0, din}, last_val <= din, iteration count <= 0, busy <= 1, go to CONV. Otherwise stay.
  - CONV: each edge applies add-3 to every BCD nibble >= 5, then shifts the 20-bit reg left by 1. After the 8th shift (edge E8), go to COMMIT.
  - COMMIT (edge E9): hund/tens/ones <= BCD nibbles; busy <= 0; go to IDLE.
  - Latency: new digits are visible after E9, i.e. 9 cycles after capture.
- din changes while busy: ignored until back in IDLE, where the IDLE compare picks up the latest din.
  - If din returns to last_val before IDLE, no reconversion.
  - Intermediate values are never displayed.
- Width rules:
  - 8-bit input, max 255, so hund is at most 2.
  - BCD nibbles are 4 bits each; the shift reg is 20 bits (12 BCD + 8 binary).
- Scan:
  - refresh counter counts 0..REFRESH_DIV-1; on wrap, digit index increments modulo 4.
  - an and seg are registered and update on the same edge as the index.
  - Each digit is lit for exactly REFRESH_DIV cycles.
- Digit content:
  - idx0 = ones, always shown.
  - idx1 = tens, blank if hund==0 and tens==0.
  - idx2 = hund, blank if 0.
  - idx3 = state_no as hex glyph 0-F, sampled when the index moves to 3.
  - The display value itself is sampled only at COMMIT.
- halt_led <= halt every cycle; 1-cycle latency.
- SEG_ACTIVE_LOW=1: seg is the bitwise inverse of the active-high glyph.

Decomposition:
- Package disp_pkg:
  - FSM state typedef {IDLE, CONV, COMMIT}.
  - Active-high glyph constants SEG_0..SEG_F and SEG_BLANK (7'b0000000).
  - NUM_DIGITS=4, BCD_W=12.
- One sub-module, bin2bcd_seq: the double-dabble engine with start/din/busy/done/bcd ports, containing the CONV iteration logic.
- Top level owns change detection, scan counter, blanking and glyph mux.

Test Plan:
- Reset: hold reset=0 for 3 cycles, din=0 -> seg blank, an=0000, busy=0. One edge after release: an=0001, seg=~SEG_0.
- Conversion: din=9 after reset -> busy high for exactly 9 cycles. Then ones=9, tens and hund blank; digit0 seg=~SEG_9.
- Max value: din=255 -> after 9 cycles digits 2,5,5. Rotating an shows ~SEG_2, ~SEG_5, ~SEG_5 on idx2/1/0.
- Change during busy: din=100, then din=37 at E4 -> 1,0,0 committed at E9. A new capture next edge; 37 committed 10 cycles later with hund blank.
- Scan and state digit: REFRESH_DIV=4, state_no=4'hA, halt=1 -> an sequence 0001, 0010, 0100, 1000, 0001 changing every 4 cycles. Idx3 seg=~SEG_A; halt_led=1 one cycle after halt.
- Reset mid-conversion: din=200, reset=0 at E3 -> busy=0, display 0, last_val=0. After release with din=200 still applied, a fresh conversion yields 2,0,0.
